seq_restoring_divider: RTL and testbench

//   Sequential restoring divider: the inverse companion of the combinational 4x4 array multiplier.
//   - Divides an unsigned DW-bit dividend by an unsigned VW-bit divisor.
//   - Produces one quotient bit per clock.
//   - Uses a start/busy/done handshake.
//   - Sits beside the multiplier in the arithmetic tile; default sizing divides an 8-bit product by a 4-bit factor.

---
 rtl/seq_restoring_divider.sv | 143 ++++++++++++++
 tb/tb_seq_restoring_divider.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider: one quotient bit per clock behind a start/busy/done handshake.
// Optional macro DIV_EARLY_EXIT_EN finishes at accept when dividend < divisor.
module seq_restoring_divider #(
  parameter int unsigned DW = 8,
  parameter int unsigned VW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int unsigned CntW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DW - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   q_q, q_d;
  logic [VW-1:0]   d_q, d_d;
  logic [VW:0]     r_q, r_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [DW-1:0]   quo_q, quo_d;
  logic [VW-1:0]   rem_q, rem_d;
  logic            dbz_q, dbz_d;

  // One restoring step: shift the next dividend bit into the partial remainder and try to subtract.
  logic [VW:0]   trial;
  logic [VW:0]   diff;
  logic          fits;
  logic [VW:0]   r_step;
  logic [DW-1:0] q_step;

  always_comb begin
    trial  = {r_q[VW-1:0], q_q[DW-1]};
    diff   = trial - {1'b0, d_q};
    fits   = (trial >= {1'b0, d_q});
    r_step = fits ? diff : trial;
    q_step = {q_q[DW-2:0], fits};
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    d_d     = d_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          q_d   = dividend;
          d_d   = divisor;
          r_d   = '0;
          cnt_d = '0;
          if (divisor == '0) begin
            quo_d   = '1;
            rem_d   = '0;
            dbz_d   = 1'b1;
            state_d = StDone;
          end
`ifdef DIV_EARLY_EXIT_EN
          else if (dividend < DW'(divisor)) begin
            quo_d   = '0;
            rem_d   = dividend[VW-1:0];
            dbz_d   = 1'b0;
            state_d = StDone;
          end
`endif
          else begin
            state_d = StRun;
          end
        end
      end

      StRun: begin
        r_d   = r_step;
        q_d   = q_step;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          quo_d   = q_step;
          rem_d   = r_step[VW-1:0];
          dbz_d   = 1'b0;
          state_d = StDone;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      q_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      d_q     <= d_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

  // A valid (non-zero-divisor) result must leave a remainder below the captured divisor.
  assert property (@(posedge clk) disable iff (rst) (done && !div_by_zero) |-> (remainder < d_q));
  assert property (@(posedge clk) disable iff (rst) done |-> busy);

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: vector table, handshake corner cases, random ops.
module tb_seq_restoring_divider;

  localparam int unsigned DW = 8;
  localparam int unsigned VW = 4;

  logic          clk;
  logic          rst;
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;

  int errors = 0;
  int checks = 0;

  seq_restoring_divider #(
    .DW(DW),
    .VW(VW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] a;
    logic [VW-1:0] b;
    logic [DW-1:0] exp_q;
    logic [VW-1:0] exp_r;
    logic          exp_dbz;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference behaviour from plain arithmetic, including the zero-divisor convention.
  task automatic model(input logic [DW-1:0] a, input logic [VW-1:0] b,
                       output logic [DW-1:0] eq, output logic [VW-1:0] er,
                       output logic edz, output int lat);
    int unsigned ai;
    int unsigned bi;
    ai = a;
    bi = b;
    if (bi == 0) begin
      eq  = '1;
      er  = '0;
      edz = 1'b1;
      lat = 0;
    end else begin
      eq  = DW'(ai / bi);
      er  = VW'(ai % bi);
      edz = 1'b0;
      lat = DW;
`ifdef DIV_EARLY_EXIT_EN
      if (ai < bi) lat = 0;
`endif
    end
  endtask

  // Accepts one op, measures edges from accept to done, checks results and the one-cycle pulse.
  task automatic run_op(input logic [DW-1:0] a, input logic [VW-1:0] b, input string tag);
    logic [DW-1:0] eq;
    logic [VW-1:0] er;
    logic          edz;
    int            lat;
    int            n;
    model(a, b, eq, er, edz, lat);
    @(negedge clk);
    check($sformatf("%s idle_before", tag), 32'(busy), 32'd0);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = DW'($urandom);
    divisor  = VW'($urandom);
    n = 0;
    while (!done && n < int'(DW) + 4) begin
      @(posedge clk);
      #1;
      n++;
    end
    check($sformatf("%s latency", tag), 32'(n), 32'(lat));
    check($sformatf("%s quotient", tag), 32'(quotient), 32'(eq));
    check($sformatf("%s remainder", tag), 32'(remainder), 32'(er));
    check($sformatf("%s div_by_zero", tag), 32'(div_by_zero), 32'(edz));
    @(posedge clk);
    #1;
    check($sformatf("%s done_pulse", tag), 32'(done), 32'd0);
  endtask

  initial begin
    int dones;
    int done_at;

    vecs[0] = '{a: 8'd143, b: 4'd11, exp_q: 8'd13,  exp_r: 4'd0,  exp_dbz: 1'b0};
    vecs[1] = '{a: 8'd255, b: 4'd1,  exp_q: 8'd255, exp_r: 4'd0,  exp_dbz: 1'b0};
    vecs[2] = '{a: 8'd255, b: 4'd15, exp_q: 8'd17,  exp_r: 4'd0,  exp_dbz: 1'b0};
    vecs[3] = '{a: 8'd254, b: 4'd15, exp_q: 8'd16,  exp_r: 4'd14, exp_dbz: 1'b0};
    vecs[4] = '{a: 8'd200, b: 4'd0,  exp_q: 8'hFF,  exp_r: 4'd0,  exp_dbz: 1'b1};
    vecs[5] = '{a: 8'd5,   b: 4'd9,  exp_q: 8'd0,   exp_r: 4'd5,  exp_dbz: 1'b0};
    vecs[6] = '{a: 8'd0,   b: 4'd3,  exp_q: 8'd0,   exp_r: 4'd0,  exp_dbz: 1'b0};
    vecs[7] = '{a: 8'd7,   b: 4'd7,  exp_q: 8'd1,   exp_r: 4'd0,  exp_dbz: 1'b0};
    vecs[8] = '{a: 8'd100, b: 4'd7,  exp_q: 8'd14,  exp_r: 4'd2,  exp_dbz: 1'b0};

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset quotient", 32'(quotient), 32'd0);
    check("reset remainder", 32'(remainder), 32'd0);
    check("reset div_by_zero", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table: results against the constant expectations, latency against the model.
    for (int i = 0; i < 9; i++) begin
      logic [DW-1:0] mq;
      logic [VW-1:0] mr;
      logic          mdz;
      int            mlat;
      model(vecs[i].a, vecs[i].b, mq, mr, mdz, mlat);
      check($sformatf("vec%0d model_q", i), 32'(mq), 32'(vecs[i].exp_q));
      run_op(vecs[i].a, vecs[i].b, $sformatf("vec%0d", i));
      check($sformatf("vec%0d table_q", i), 32'(quotient), 32'(vecs[i].exp_q));
      check($sformatf("vec%0d table_r", i), 32'(remainder), 32'(vecs[i].exp_r));
      check($sformatf("vec%0d table_dbz", i), 32'(div_by_zero), 32'(vecs[i].exp_dbz));
    end

    // Start pulses in RUN cycle 3 and in the DONE cycle must both be ignored.
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'd100;
    divisor  = 4'd7;
    @(posedge clk);
    #1;
    start   = 1'b0;
    dones   = 0;
    done_at = -1;
    for (int i = 1; i <= int'(DW) + 3; i++) begin
      @(negedge clk);
      start    = (i == 3) || (i == int'(DW) + 1);
      dividend = 8'd50;
      divisor  = 4'd5;
      @(posedge clk);
      #1;
      if (done) begin
        dones++;
        done_at = i;
      end
    end
    start = 1'b0;
    check("ignore done_count", 32'(dones), 32'd1);
    check("ignore done_edge", 32'(done_at), 32'(DW));
    check("ignore quotient", 32'(quotient), 32'd14);
    check("ignore remainder", 32'(remainder), 32'd2);
    check("ignore busy_after", 32'(busy), 32'd0);

    // Synchronous reset mid-RUN discards the op and clears the held results.
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'd143;
    divisor  = 4'd11;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst quotient", 32'(quotient), 32'd0);
    check("midrst remainder", 32'(remainder), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (DW + 2) begin
      @(posedge clk);
      #1;
      if (done) check("midrst stale_done", 32'(done), 32'd0);
    end
    run_op(8'd100, 4'd7, "after_rst");

    for (int i = 0; i < 40; i++) begin
      run_op(DW'($urandom_range(0, 255)), VW'($urandom_range(0, 15)), $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
